// File: rtl/tt_um_uart_tx.sv
// tt_um_uart_tx: fixed-baud 8N1 UART transmitter for a Tiny Tapeout tile.
// A rising edge on uio_in[0] latches ui_in and sends it LSB first on uo_out[0].
// uo_out[1] is busy, uo_out[2] is a one-cycle done pulse when the frame ends.
//
// state | meaning
// IDLE  | line high, waiting for a start edge
// START | start bit (line low) for one bit time
// DATA  | eight data bits, LSB first
// STOP  | stop bit (line high), then back to IDLE with done
module tt_um_uart_tx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [7:0]    shreg, shreg_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [BW-1:0] baud, baud_n;
  logic          tx, tx_n;
  logic          busy, busy_n;
  logic          done, done_n;
  logic          start_prev;
  logic          start_edge;
  logic          bit_end;

  // ena and the upper strobe bits have no function in this tile
  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in[7:1]};

  assign start_edge = uio_in[0] & ~start_prev;
  assign bit_end    = (baud == BAUD_LAST);

  // State and registered outputs; start_prev resets high so a held strobe does not fire
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= 8'h00;
      bit_idx    <= 3'd0;
      baud       <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      start_prev <= 1'b1;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bit_idx    <= bit_idx_n;
      baud       <= baud_n;
      tx         <= tx_n;
      busy       <= busy_n;
      done       <= done_n;
      start_prev <= uio_in[0];
    end
  end

  // Next-state, bit timing and next output values
  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_idx_n = bit_idx;
    baud_n    = baud;
    tx_n      = tx;
    busy_n    = busy;
    done_n    = 1'b0;

    case (state)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        baud_n = '0;
        if (start_edge) begin
          shreg_n   = ui_in;
          bit_idx_n = 3'd0;
          state_n   = START;
          tx_n      = 1'b0;
          busy_n    = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          baud_n    = '0;
          bit_idx_n = 3'd0;
          state_n   = DATA;
          tx_n      = shreg[0];
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_n  = '0;
          shreg_n = shreg >> 1;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            tx_n      = shreg[1];
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_n  = '0;
          state_n = IDLE;
          tx_n    = 1'b1;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
        baud_n  = '0;
      end
    endcase
  end

  assign uo_out  = {5'b00000, done, busy, tx};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_uart_tx.sv
// Testbench for tt_um_uart_tx with CLKS_PER_BIT=16. Expected line levels come
// from the 8N1 frame definition: bit slot k/CPB of {start, d0..d7, stop}.
module tb_tt_um_uart_tx;

  localparam int CPB = 16;
  localparam int NF  = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int total = 0;
  int bad   = 0;

  logic obs_tx   [0:NF];
  logic obs_busy [0:NF];
  logic obs_done [0:NF];

  tt_um_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  // Reference: line level k cycles after the accepted start edge
  function automatic logic exp_tx(input logic [7:0] d, input int k);
    int slot;
    if (k >= NF) return 1'b1;
    slot = k / CPB;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return d[slot-1];
  endfunction

  // Present a byte and raise the strobe so the next posedge sees the edge
  task automatic start_frame(input logic [7:0] d);
    @(negedge clk);
    ui_in     = d;
    uio_in[0] = 1'b1;
  endtask

  // Record tx/busy/done on each negedge k=0..NF after the start edge.
  // Optionally pulse the strobe mid-frame, and optionally arm the next frame
  // during the done cycle.
  task automatic run_frame(input int inj_k, input logic [7:0] inj_data,
                           input bit arm_next, input logic [7:0] next_data);
    for (int k = 0; k <= NF; k++) begin
      @(negedge clk);
      obs_tx[k]   = uo_out[0];
      obs_busy[k] = uo_out[1];
      obs_done[k] = uo_out[2];
      if (k == 0 || k == inj_k + 1) uio_in[0] = 1'b0;
      if (k == inj_k) begin
        ui_in     = inj_data;
        uio_in[0] = 1'b1;
      end
      if (k == NF && arm_next) begin
        ui_in     = next_data;
        uio_in[0] = 1'b1;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    uio_in = 8'h00;
    idle_cycles(3);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      total++;
      if (uo_out !== 8'h01) begin
        bad++;
        $display("FAIL reset_idle cycle=%0d uo_out=%h want 01", i, uo_out);
      end
    end
    total++;
    if (uio_oe !== 8'h00 || uio_out !== 8'h00) begin
      bad++;
      $display("FAIL reset_uio oe=%h out=%h want 00 00", uio_oe, uio_out);
    end
  endtask

  task automatic test_frame_a5;
    logic [9:0] centre_bits;
    int ndone;
    centre_bits = 10'b1101001010;   // read from bit 0: 0,1,0,1,0,0,1,0,1,1
    start_frame(8'hA5);
    run_frame(-5, 8'h00, 1'b0, 8'h00);
    for (int b = 0; b < 10; b++) begin
      total++;
      if (obs_tx[b*CPB + CPB/2] !== centre_bits[b]) begin
        bad++;
        $display("FAIL a5_centre bit=%0d tx=%b want %b", b, obs_tx[b*CPB + CPB/2], centre_bits[b]);
      end
    end
    ndone = 0;
    for (int k = 0; k <= NF; k++) if (obs_done[k] === 1'b1) ndone++;
    total++;
    if (ndone != 1 || obs_done[NF] !== 1'b1) begin
      bad++;
      $display("FAIL a5_done count=%0d at160=%b want 1 1", ndone, obs_done[NF]);
    end
    for (int k = 0; k <= NF; k++) begin
      total++;
      if (obs_tx[k] !== exp_tx(8'hA5, k) || obs_busy[k] !== (k < NF) || obs_done[k] !== (k == NF)) begin
        bad++;
        $display("FAIL a5_frame k=%0d tx/busy/done=%b%b%b want %b%b%b", k,
                 obs_tx[k], obs_busy[k], obs_done[k], exp_tx(8'hA5, k), k < NF, k == NF);
      end
    end
  endtask

  task automatic test_random;
    logic [7:0] d;
    for (int n = 0; n < 6; n++) begin
      d = 8'($urandom);
      start_frame(d);
      run_frame(-5, 8'h00, 1'b0, 8'h00);
      for (int k = 0; k <= NF; k++) begin
        total++;
        if (obs_tx[k] !== exp_tx(d, k) || obs_busy[k] !== (k < NF) || obs_done[k] !== (k == NF)) begin
          bad++;
          $display("FAIL rand_frame byte=%h k=%0d tx/busy/done=%b%b%b want %b%b%b", d, k,
                   obs_tx[k], obs_busy[k], obs_done[k], exp_tx(d, k), k < NF, k == NF);
        end
      end
      idle_cycles(int'($urandom_range(0, 20)));
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] seq [2];
    seq[0] = 8'h00;
    seq[1] = 8'hFF;
    start_frame(seq[0]);
    for (int f = 0; f < 2; f++) begin
      run_frame(-5, 8'h00, f == 0, seq[1]);
      for (int k = 0; k <= NF; k++) begin
        total++;
        if (obs_tx[k] !== exp_tx(seq[f], k) || obs_busy[k] !== (k < NF) || obs_done[k] !== (k == NF)) begin
          bad++;
          $display("FAIL b2b_frame%0d k=%0d tx/busy/done=%b%b%b want %b%b%b", f, k,
                   obs_tx[k], obs_busy[k], obs_done[k], exp_tx(seq[f], k), k < NF, k == NF);
        end
      end
    end
  endtask

  task automatic test_mid_strobe;
    logic [7:0] d;
    int ndone;
    d = 8'($urandom);
    start_frame(d);
    run_frame(5*CPB + 3, 8'h3C, 1'b0, 8'h00);
    ndone = 0;
    for (int k = 0; k <= NF; k++) begin
      if (obs_done[k] === 1'b1) ndone++;
      total++;
      if (obs_tx[k] !== exp_tx(d, k) || obs_busy[k] !== (k < NF)) begin
        bad++;
        $display("FAIL mid_strobe byte=%h k=%0d tx/busy=%b%b want %b%b", d, k,
                 obs_tx[k], obs_busy[k], exp_tx(d, k), k < NF);
      end
    end
    total++;
    if (ndone != 1) begin
      bad++;
      $display("FAIL mid_strobe_done count=%0d want 1", ndone);
    end
    for (int i = 0; i < 2*CPB; i++) begin
      @(negedge clk);
      total++;
      if (uo_out !== 8'h01) begin
        bad++;
        $display("FAIL mid_strobe_after cycle=%0d uo_out=%h want 01", i, uo_out);
      end
    end
  endtask

  task automatic test_held_through_reset;
    @(negedge clk);
    ui_in     = 8'h96;
    uio_in[0] = 1'b1;
    rst       = 1'b1;
    idle_cycles(2);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      total++;
      if (uo_out !== 8'h01) begin
        bad++;
        $display("FAIL held_strobe cycle=%0d uo_out=%h want 01", i, uo_out);
      end
    end
    uio_in[0] = 1'b0;
    start_frame(8'h96);
    run_frame(-5, 8'h00, 1'b0, 8'h00);
    for (int k = 0; k <= NF; k++) begin
      total++;
      if (obs_tx[k] !== exp_tx(8'h96, k) || obs_busy[k] !== (k < NF) || obs_done[k] !== (k == NF)) begin
        bad++;
        $display("FAIL held_frame k=%0d tx/busy/done=%b%b%b want %b%b%b", k,
                 obs_tx[k], obs_busy[k], obs_done[k], exp_tx(8'h96, k), k < NF, k == NF);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] d;
    start_frame(8'h5A);
    for (int k = 0; k <= 3*CPB + 5; k++) begin
      @(negedge clk);
      if (k == 0) uio_in[0] = 1'b0;
    end
    total++;
    if (uo_out[1] !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre busy=%b want 1", uo_out[1]);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (uo_out !== 8'h01) begin
      bad++;
      $display("FAIL abort_reset uo_out=%h want 01", uo_out);
    end
    rst = 1'b0;
    for (int i = 0; i < 12*CPB; i++) begin
      @(negedge clk);
      total++;
      if (uo_out !== 8'h01) begin
        bad++;
        $display("FAIL abort_quiet cycle=%0d uo_out=%h want 01", i, uo_out);
      end
    end
    d = 8'($urandom);
    start_frame(d);
    run_frame(-5, 8'h00, 1'b0, 8'h00);
    for (int k = 0; k <= NF; k++) begin
      total++;
      if (obs_tx[k] !== exp_tx(d, k) || obs_busy[k] !== (k < NF) || obs_done[k] !== (k == NF)) begin
        bad++;
        $display("FAIL abort_clean byte=%h k=%0d tx/busy/done=%b%b%b want %b%b%b", d, k,
                 obs_tx[k], obs_busy[k], obs_done[k], exp_tx(d, k), k < NF, k == NF);
      end
    end
  endtask

  initial begin
    test_reset;
    test_frame_a5;
    test_random;
    test_back_to_back;
    test_mid_strobe;
    test_held_through_reset;
    test_reset_mid_frame;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
